// File: rtl/codec_sad_pkg.sv
// Shared types and helpers for the SAD block sequencer.
// Block size codes, width lookup and accumulator sizing.
package codec_sad_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [1:0] BLK_4X4   = 2'd0;
   localparam logic [1:0] BLK_8X8   = 2'd1;
   localparam logic [1:0] BLK_16X16 = 2'd2;
   localparam logic [1:0] BLK_BAD   = 2'd3;

   // 8 guard bits cover 256 pixels of full-scale difference
   localparam int SAD_GUARD = 8;

   function automatic int sad_w(input int dw);
      return dw + SAD_GUARD;
   endfunction

   function automatic logic [4:0] blk_w(input logic [1:0] bs);
      logic [4:0] w;
      case (bs)
         BLK_4X4:   w = 5'd4;
         BLK_8X8:   w = 5'd8;
         BLK_16X16: w = 5'd16;
         default:   w = 5'd4;
      endcase
      return w;
   endfunction

   function automatic logic [3:0] blk_last(input logic [1:0] bs);
      logic [4:0] m;
      m = blk_w(bs) - 5'd1;
      return m[3:0];
   endfunction

endpackage

// File: rtl/codec_sad_addr_gen.sv
// Row/column walker for one SAD block.
// Keeps incremental cur/ref addresses; holds them while stalled.
module codec_sad_addr_gen #(
   parameter int AW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          issue,
   input  logic [3:0]    wm1,
   input  logic [AW-1:0] cur_base,
   input  logic [AW-1:0] ref_base,
   input  logic [AW-1:0] stride,
   output logic [AW-1:0] cur_addr,
   output logic [AW-1:0] ref_addr,
   output logic          last
);

   localparam logic [AW-1:0] ONE = AW'(1);

   logic [3:0]    wm1_q;
   logic [3:0]    col;
   logic [3:0]    row;
   logic [AW-1:0] stride_q;
   logic [AW-1:0] cur_line;
   logic [AW-1:0] ref_line;
   logic          eol;

   assign eol  = (col == wm1_q);
   assign last = eol && (row == wm1_q);

   // Counters and address registers; advance only on an issued read
   always_ff @(posedge clk) begin
      if (rst) begin
         wm1_q    <= '0;
         col      <= '0;
         row      <= '0;
         stride_q <= '0;
         cur_line <= '0;
         ref_line <= '0;
         cur_addr <= '0;
         ref_addr <= '0;
      end else if (load) begin
         wm1_q    <= wm1;
         col      <= '0;
         row      <= '0;
         stride_q <= stride;
         cur_line <= cur_base;
         ref_line <= ref_base;
         cur_addr <= cur_base;
         ref_addr <= ref_base;
      end else if (issue) begin
         if (eol) begin
            col      <= '0;
            row      <= row + 4'd1;
            cur_line <= cur_line + stride_q;
            ref_line <= ref_line + stride_q;
            cur_addr <= cur_line + stride_q;
            ref_addr <= ref_line + stride_q;
         end else begin
            col      <= col + 4'd1;
            cur_addr <= cur_addr + ONE;
            ref_addr <= ref_addr + ONE;
         end
      end
   end

endmodule

// File: rtl/codec_sad_blk_ctrl.sv
// SAD lane sequencer: walks a block, reads both frames,
// accumulates |cur-ref| and reports the block SAD.
module codec_sad_blk_ctrl
   import codec_sad_pkg::*;
#(
   parameter int DW    = 8,
   parameter int AW    = 16,
   parameter int SAD_W = sad_w(DW)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       blk_size,
   input  logic [AW-1:0]    cur_base,
   input  logic [AW-1:0]    ref_base,
   input  logic [AW-1:0]    stride,
   output logic             rd_req,
   input  logic             rd_gnt,
   output logic [AW-1:0]    cur_addr,
   output logic [AW-1:0]    ref_addr,
   input  logic [DW-1:0]    cur_data,
   input  logic [DW-1:0]    ref_data,
   output logic             busy,
   output logic             sad_vld,
   output logic [SAD_W-1:0] sad,
   output logic             cfg_err
);

   state_t           state;
   state_t           state_nxt;
   logic             accept;
   logic             bad_cfg;
   logic             issue;
   logic             last;
   logic             drain_done;
   logic             d_vld;
   logic             x_vld;
   logic [DW-1:0]    diff;
   logic [SAD_W-1:0] acc;
   logic [SAD_W-1:0] acc_nxt;

   assign accept  = (state == IDLE) && start && (blk_size != BLK_BAD);
   assign bad_cfg = (state == IDLE) && start && (blk_size == BLK_BAD);
   assign issue   = rd_req && rd_gnt;

   // Once no data is in flight, the last diff retires into acc this edge
   assign drain_done = !d_vld;

   assign acc_nxt = x_vld ? acc + {{(SAD_W-DW){1'b0}}, diff} : acc;

   codec_sad_addr_gen #(
      .AW (AW)
   ) u_addr (
      .clk      (clk),
      .rst      (rst),
      .load     (accept),
      .issue    (issue),
      .wm1      (blk_last(blk_size)),
      .cur_base (cur_base),
      .ref_base (ref_base),
      .stride   (stride),
      .cur_addr (cur_addr),
      .ref_addr (ref_addr),
      .last     (last)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state and state-decoded outputs
   always_comb begin
      state_nxt = state;
      rd_req    = 1'b0;
      busy      = 1'b1;
      sad_vld   = 1'b0;
      unique case (state)
         IDLE: begin
            busy = 1'b0;
            if (accept) state_nxt = RUN;
         end
         RUN: begin
            rd_req = 1'b1;
            if (rd_gnt && last) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (drain_done) state_nxt = DONE;
         end
         DONE: begin
            sad_vld   = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Read-data and abs-diff stages, each with its own valid
   always_ff @(posedge clk) begin
      if (rst) begin
         d_vld <= 1'b0;
         x_vld <= 1'b0;
         diff  <= '0;
      end else begin
         d_vld <= issue;
         x_vld <= d_vld;
         if (d_vld) begin
            diff <= (cur_data >= ref_data) ? cur_data - ref_data
                                           : ref_data - cur_data;
         end
      end
   end

   // Accumulator and published result
   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
         sad <= '0;
      end else if (accept) begin
         acc <= '0;
         sad <= '0;
      end else begin
         acc <= acc_nxt;
         if ((state == DRAIN) && drain_done) sad <= acc_nxt;
      end
   end

   // Illegal block size flag, one cycle after the rejected start
   always_ff @(posedge clk) begin
      if (rst) cfg_err <= 1'b0;
      else     cfg_err <= bad_cfg;
   end

endmodule

// File: tb/tb_codec_sad_blk_ctrl.sv
// Self-checking bench for codec_sad_blk_ctrl.
// SRAM model and SAD reference computed from plain block arithmetic.
module tb_codec_sad_blk_ctrl;

   localparam int DW    = 8;
   localparam int AW    = 16;
   localparam int SAD_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [1:0]       blk_size;
   logic [AW-1:0]    cur_base;
   logic [AW-1:0]    ref_base;
   logic [AW-1:0]    stride;
   logic             rd_req;
   logic             rd_gnt;
   logic [AW-1:0]    cur_addr;
   logic [AW-1:0]    ref_addr;
   logic [DW-1:0]    cur_data;
   logic [DW-1:0]    ref_data;
   logic             busy;
   logic             sad_vld;
   logic [SAD_W-1:0] sad;
   logic             cfg_err;

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] cur_mem [0:65535];
   logic [DW-1:0] ref_mem [0:65535];

   int            n_iss, first_iss, last_iss, vld_cnt, vld_cyc, idle_cyc;
   int            stalls, addr_errs, hold_errs;
   bit            timeout;
   logic [15:0]   vld_sad;
   logic [15:0]   iss_cur [$];

   always #5 clk = ~clk;

   codec_sad_blk_ctrl #(
      .DW    (DW),
      .AW    (AW),
      .SAD_W (SAD_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .blk_size (blk_size),
      .cur_base (cur_base),
      .ref_base (ref_base),
      .stride   (stride),
      .rd_req   (rd_req),
      .rd_gnt   (rd_gnt),
      .cur_addr (cur_addr),
      .ref_addr (ref_addr),
      .cur_data (cur_data),
      .ref_data (ref_data),
      .busy     (busy),
      .sad_vld  (sad_vld),
      .sad      (sad),
      .cfg_err  (cfg_err)
   );

   function automatic logic [15:0] pix_addr(input logic [15:0] base, input logic [15:0] st, input int k, input int w);
      return 16'(int'(base) + (k / w) * int'(st) + (k % w));
   endfunction

   // mode 0: constant cv/rv; mode 1: random ref, cur = ref + k%5
   task automatic fill(input logic [1:0] bs, input logic [15:0] cb, input logic [15:0] rb, input logic [15:0] st, input int mode, input int cv, input int rv);
      int w;
      int r;
      w = 4 << bs;
      for (int k = 0; k < w * w; k++) begin
         if (mode == 0) begin
            cur_mem[pix_addr(cb, st, k, w)] = 8'(cv);
            ref_mem[pix_addr(rb, st, k, w)] = 8'(rv);
         end else begin
            r = $urandom_range(250, 0);
            ref_mem[pix_addr(rb, st, k, w)] = 8'(r);
            cur_mem[pix_addr(cb, st, k, w)] = 8'(r + k % 5);
         end
      end
   endtask

   function automatic int model_sad(input logic [1:0] bs, input logic [15:0] cb, input logic [15:0] rb, input logic [15:0] st);
      int w;
      int s;
      int a;
      int b;
      w = 4 << bs;
      s = 0;
      for (int k = 0; k < w * w; k++) begin
         a = int'(cur_mem[pix_addr(cb, st, k, w)]);
         b = int'(ref_mem[pix_addr(rb, st, k, w)]);
         s += (a > b) ? a - b : b - a;
      end
      return s;
   endfunction

   // Drives one block and acts as the SRAM; records what happened
   task automatic run_block(input logic [1:0] bs, input logic [15:0] cb, input logic [15:0] rb, input logic [15:0] st, input bit rnd, input int poke, input int rst_at);
      int w;
      int cyc;
      bit gnt;
      bit iss;
      bit hv;
      bit fin;
      logic [15:0] hc, hr, ic, ir;
      w = 4 << bs;
      n_iss = 0; first_iss = -1; last_iss = -1; vld_cnt = 0;
      vld_cyc = -1; idle_cyc = -1; stalls = 0; addr_errs = 0;
      hold_errs = 0; vld_sad = '0; timeout = 1'b1; iss_cur.delete();
      hv = 1'b0; hc = '0; hr = '0; ic = '0; ir = '0; fin = 1'b0;
      @(negedge clk);
      start = 1'b1; blk_size = bs; cur_base = cb; ref_base = rb; stride = st;
      rd_gnt = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc = 1;
      for (int b = 0; b < 3000 && !fin; b++) begin
         @(negedge clk);
         gnt = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
         rd_gnt = gnt;
         if (cyc == poke) begin
            start = 1'b1; blk_size = 2'd2;
            cur_base = 16'h5000; ref_base = 16'h6000; stride = 16'd16;
         end
         if (rst_at >= 0 && n_iss == rst_at) rst = 1'b1;
         if (hv && rd_req && (cur_addr !== hc || ref_addr !== hr)) hold_errs++;
         hv = rd_req && !gnt;
         hc = cur_addr;
         hr = ref_addr;
         if (rd_req && !gnt) stalls++;
         iss = rd_req && gnt;
         if (iss) begin
            if (cur_addr !== pix_addr(cb, st, n_iss, w) || ref_addr !== pix_addr(rb, st, n_iss, w)) addr_errs++;
            iss_cur.push_back(cur_addr);
            if (n_iss == 0) first_iss = cyc;
            last_iss = cyc;
            n_iss++;
            ic = cur_addr;
            ir = ref_addr;
         end
         if (sad_vld) begin
            vld_cnt++;
            vld_cyc = cyc;
            vld_sad = sad;
         end
         if (vld_cnt > 0 && !busy) begin
            idle_cyc = cyc;
            timeout = 1'b0;
            fin = 1'b1;
         end else begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (rst) begin
               rst = 1'b0;
               timeout = 1'b0;
               fin = 1'b1;
            end else begin
               if (iss) begin
                  cur_data = cur_mem[ic];
                  ref_data = ref_mem[ir];
               end
               cyc++;
            end
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; rd_gnt = 1'b0; blk_size = 2'd0;
      cur_base = '0; ref_base = '0; stride = '0; cur_data = '0; ref_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (rd_req !== 1'b0) begin failures++; $display("FAIL reset_rd_req: got %0d exp 0", rd_req); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0d exp 0", busy); end
      checks++; if (sad_vld !== 1'b0) begin failures++; $display("FAIL reset_sad_vld: got %0d exp 0", sad_vld); end
      checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL reset_cfg_err: got %0d exp 0", cfg_err); end
      checks++; if (sad !== 16'd0) begin failures++; $display("FAIL reset_sad: got %0d exp 0", sad); end
      checks++; if (cur_addr !== 16'd0 || ref_addr !== 16'd0) begin failures++; $display("FAIL reset_addr: got %h/%h exp 0000/0000", cur_addr, ref_addr); end
   endtask

   task automatic test_basic_4x4;
      fill(2'd0, 16'h0100, 16'h0200, 16'd32, 0, 10, 3);
      run_block(2'd0, 16'h0100, 16'h0200, 16'd32, 1'b0, -1, -1);
      checks++; if (timeout) begin failures++; $display("FAIL basic_timeout: got 1 exp 0"); end
      checks++; if (n_iss !== 16) begin failures++; $display("FAIL basic_issues: got %0d exp 16", n_iss); end
      checks++; if (first_iss !== 1 || last_iss !== 16) begin failures++; $display("FAIL basic_issue_window: got %0d..%0d exp 1..16", first_iss, last_iss); end
      checks++; if (vld_cnt !== 1 || vld_cyc !== 19) begin failures++; $display("FAIL basic_vld: got cnt %0d cyc %0d exp 1/19", vld_cnt, vld_cyc); end
      checks++; if (vld_sad !== 16'd112) begin failures++; $display("FAIL basic_sad: got %0d exp 112", vld_sad); end
      checks++; if (idle_cyc !== 20) begin failures++; $display("FAIL basic_idle: got %0d exp 20", idle_cyc); end
      checks++; if (addr_errs !== 0) begin failures++; $display("FAIL basic_addr: got %0d bad exp 0", addr_errs); end
   endtask

   task automatic test_max_16x16;
      for (int s = 0; s < 2; s++) begin
         fill(2'd2, 16'h1000, 16'h8000, 16'd16, 0, (s == 0) ? 255 : 0, (s == 0) ? 0 : 255);
         run_block(2'd2, 16'h1000, 16'h8000, 16'd16, 1'b0, -1, -1);
         checks++; if (timeout) begin failures++; $display("FAIL max_timeout: got 1 exp 0"); end
         checks++; if (n_iss !== 256) begin failures++; $display("FAIL max_issues: got %0d exp 256", n_iss); end
         checks++; if (vld_sad !== 16'd65280) begin failures++; $display("FAIL max_sad: got %0d exp 65280", vld_sad); end
         checks++; if (vld_cyc !== 259 || vld_cnt !== 1) begin failures++; $display("FAIL max_latency: got cyc %0d cnt %0d exp 259/1", vld_cyc, vld_cnt); end
      end
   endtask

   task automatic test_random_stall;
      logic [15:0] cb, rb, st;
      int exp_sad;
      for (int it = 0; it < 3; it++) begin
         cb = 16'($urandom);
         rb = 16'($urandom);
         st = 16'($urandom_range(64, 8));
         fill(2'd1, cb, rb, st, 1, 0, 0);
         exp_sad = model_sad(2'd1, cb, rb, st);
         run_block(2'd1, cb, rb, st, 1'b1, -1, -1);
         checks++; if (timeout) begin failures++; $display("FAIL rnd_timeout: got 1 exp 0"); end
         checks++; if (n_iss !== 64) begin failures++; $display("FAIL rnd_issues: got %0d exp 64", n_iss); end
         checks++; if (int'(vld_sad) !== exp_sad) begin failures++; $display("FAIL rnd_sad: got %0d exp %0d", vld_sad, exp_sad); end
         checks++; if (hold_errs !== 0) begin failures++; $display("FAIL rnd_hold: got %0d moved exp 0", hold_errs); end
         checks++; if (addr_errs !== 0) begin failures++; $display("FAIL rnd_addr: got %0d bad exp 0", addr_errs); end
         checks++; if (vld_cyc !== 67 + stalls) begin failures++; $display("FAIL rnd_latency: got %0d exp %0d", vld_cyc, 67 + stalls); end
         checks++; if (vld_cyc !== last_iss + 3) begin failures++; $display("FAIL rnd_tail: got %0d exp %0d", vld_cyc, last_iss + 3); end
         checks++; if (stalls == 0) begin failures++; $display("FAIL rnd_stalls: got 0 exp >0"); end
      end
   endtask

   task automatic test_addr_wrap;
      logic [15:0] exp_seq [8];
      exp_seq = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001,
                  16'h0002, 16'h0003, 16'h0004, 16'h0005};
      fill(2'd0, 16'hFFFE, 16'h3000, 16'd4, 0, 20, 25);
      run_block(2'd0, 16'hFFFE, 16'h3000, 16'd4, 1'b0, -1, -1);
      checks++; if (timeout || n_iss !== 16) begin failures++; $display("FAIL wrap_issues: got %0d exp 16", n_iss); end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (i >= iss_cur.size() || iss_cur[i] !== exp_seq[i]) begin
            failures++;
            $display("FAIL wrap_addr%0d: got %h exp %h", i, (i < iss_cur.size()) ? iss_cur[i] : 16'hxxxx, exp_seq[i]);
         end
      end
      checks++; if (vld_sad !== 16'd80) begin failures++; $display("FAIL wrap_sad: got %0d exp 80", vld_sad); end
   endtask

   task automatic test_busy_start;
      int exp_sad;
      int pk;
      fill(2'd0, 16'h0400, 16'h0800, 16'd16, 1, 0, 0);
      exp_sad = model_sad(2'd0, 16'h0400, 16'h0800, 16'd16);
      for (int p = 0; p < 2; p++) begin
         pk = (p == 0) ? 5 : 19;
         run_block(2'd0, 16'h0400, 16'h0800, 16'd16, 1'b0, pk, -1);
         checks++; if (timeout || n_iss !== 16) begin failures++; $display("FAIL busy_start_issues: got %0d exp 16", n_iss); end
         checks++; if (addr_errs !== 0) begin failures++; $display("FAIL busy_start_addr: got %0d bad exp 0", addr_errs); end
         checks++; if (int'(vld_sad) !== exp_sad || vld_cyc !== 19) begin failures++; $display("FAIL busy_start_sad: got %0d@%0d exp %0d@19", vld_sad, vld_cyc, exp_sad); end
         repeat (3) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || rd_req !== 1'b0 || sad_vld !== 1'b0 || int'(sad) !== exp_sad) begin
               failures++;
               $display("FAIL busy_start_hold: got busy %0d req %0d vld %0d sad %0d exp 0/0/0/%0d", busy, rd_req, sad_vld, sad, exp_sad);
            end
         end
      end
   endtask

   task automatic test_cfg_err;
      logic [15:0] prev;
      prev = sad;
      @(negedge clk);
      start = 1'b1; blk_size = 2'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL cfg_err_pulse: got %0d exp 1", cfg_err); end
      checks++; if (busy !== 1'b0 || rd_req !== 1'b0) begin failures++; $display("FAIL cfg_err_busy: got %0d/%0d exp 0/0", busy, rd_req); end
      @(negedge clk);
      checks++; if (cfg_err !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL cfg_err_width: got %0d busy %0d exp 0/0", cfg_err, busy); end
      checks++; if (sad !== prev) begin failures++; $display("FAIL cfg_err_sad: got %0d exp %0d", sad, prev); end
   endtask

   task automatic test_reset_mid;
      int exp_sad;
      int bad;
      fill(2'd1, 16'h2000, 16'h2400, 16'd8, 1, 0, 0);
      exp_sad = model_sad(2'd1, 16'h2000, 16'h2400, 16'd8);
      run_block(2'd1, 16'h2000, 16'h2400, 16'd8, 1'b0, -1, 7);
      checks++; if (timeout || vld_cnt !== 0) begin failures++; $display("FAIL rstmid_run: got timeout %0d vld %0d exp 0/0", timeout, vld_cnt); end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || rd_req !== 1'b0 || sad_vld !== 1'b0 || cfg_err !== 1'b0 || sad !== 16'd0 || cur_addr !== 16'd0 || ref_addr !== 16'd0) begin
         failures++;
         $display("FAIL rstmid_outputs: got busy %0d req %0d vld %0d err %0d sad %0d addr %h/%h exp all 0", busy, rd_req, sad_vld, cfg_err, sad, cur_addr, ref_addr);
      end
      bad = 0;
      repeat (80) begin
         @(negedge clk);
         if (sad_vld || busy) bad++;
      end
      checks++; if (bad !== 0) begin failures++; $display("FAIL rstmid_quiet: got %0d active cycles exp 0", bad); end
      run_block(2'd1, 16'h2000, 16'h2400, 16'd8, 1'b0, -1, -1);
      checks++; if (timeout || n_iss !== 64) begin failures++; $display("FAIL rstmid_rerun_issues: got %0d exp 64", n_iss); end
      checks++; if (int'(vld_sad) !== exp_sad || vld_cyc !== 67) begin failures++; $display("FAIL rstmid_rerun_sad: got %0d@%0d exp %0d@67", vld_sad, vld_cyc, exp_sad); end
   endtask

   initial begin
      test_reset();
      test_basic_4x4();
      test_max_16x16();
      test_random_stall();
      test_addr_wrap();
      test_busy_start();
      test_cfg_err();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/codec_sad_blk_ctrl.md
Name: codec_sad_blk_ctrl

Overview:
Sequencer for one SAD (sum of absolute differences) lane in the motion-estimation path. On start it walks a 4x4, 8x8 or 16x16 block and issues paired reads to the current-frame and reference-frame pixel SRAMs through a shared-port request/grant handshake. It forms |cur-ref| per pixel in a one-cycle registered stage, accumulates the block SAD and reports it with a single-cycle valid pulse.

Parameters:
DW, 8, pixel width
AW, 16, SRAM address width
SAD_W, DW+8, accumulator/result width; holds 256 * (2^DW - 1) without overflow

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  launch one block; sampled only in IDLE
blk_size  in  2  0=4x4, 1=8x8, 2=16x16, 3=illegal
cur_base  in  AW  current-block top-left address; sampled with start
ref_base  in  AW  reference-block top-left address; sampled with start
stride  in  AW  line pitch shared by both frames; sampled with start
rd_req  out  1  read request; cur_addr and ref_addr are valid while high
rd_gnt  in  1  grant; a read issues when rd_req && rd_gnt
cur_addr  out  AW  current-frame address
ref_addr  out  AW  reference-frame address
cur_data  in  DW  current pixel, valid the cycle after an issue
ref_data  in  DW  reference pixel, valid the cycle after an issue
busy  out  1  high in every state except IDLE
sad_vld  out  1  one-cycle pulse when sad is final
sad  out  SAD_W  block SAD; holds its value until the next accepted start
cfg_err  out  1  one-cycle pulse when start arrives with blk_size==3

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state=IDLE. rd_req, busy, sad_vld and cfg_err are 0. sad, the accumulator, the counters, the address registers and the pipeline valids are 0. A reset mid-block aborts immediately: no sad_vld, and in-flight data is discarded.
- States:
  - IDLE: on start with blk_size<=2, latch the config, clear the accumulator and sad, and go to RUN. On start with blk_size==3, pulse cfg_err the next cycle and stay in IDLE.
  - RUN: rd_req=1. On each issue, advance col. When col hits W-1, set col=0 and increment row. After the issue at (W-1, W-1), go to DRAIN.
  - DRAIN: rd_req=0. Wait until the read stage and the abs-diff stage are both empty, then go to DONE.
  - DONE: sad_vld=1 for one cycle, then go to IDLE.
- start is ignored whenever busy=1.
- W = 4/8/16 and N = W*W.
- Address rules:
  - cur_addr = cur_base + row*stride + col, modulo 2^AW (wraps silently). ref_addr is computed the same way from ref_base.
  - Addresses are held by incremental registers: add 1 per column, and step to the line base plus stride per row. No multiplier.
  - Addresses are stable while rd_req=1 and rd_gnt=0.
- Pipeline:
  - Issue cycle t: cur_data/ref_data are valid at t+1.
  - The diff register loads |cur-ref| (DW bits, computed from the larger minus the smaller) at the end of t+1 and is valid at t+2.
  - The accumulator adds the zero-extended diff at the end of t+2.
- Latency with rd_gnt tied to 1: start sampled at edge 0, first issue in cycle 1, last issue in cycle N, sad_vld in cycle N+3. The 4x4 case gives 19.
- Stalls: rd_gnt=0 inserts bubbles. Data and diff stages carry their own valid bits; bubbles do not change the accumulator, and stalled cycles add to latency only.
- Overflow cannot occur under SAD_W. No saturation logic.
- sad updates once, when entering DONE.

Decomposition:
- Package codec_sad_pkg:
  - state enum {IDLE, RUN, DRAIN, DONE}
  - blk_size encodings and a W lookup (4/8/16)
  - SAD_W derivation
- Sub-module codec_sad_addr_gen: row/col counters, last-pixel flag, and incremental cur/ref address registers with stall hold.
- The abs-diff and accumulator stage stays in the top level.

Test Plan:
- blk_size=0, cur all 10, ref all 3, rd_gnt=1, start at cycle 0 -> 16 issues in cycles 1..16; sad_vld only in cycle 19 with sad=112; busy low from cycle 20.
- blk_size=2, cur=255, ref=0 (then swap cur/ref) -> sad=65280 both runs; no wrap; exactly 256 issues.
- blk_size=1, cur=ref+(i%5) random, rd_gnt random 50% -> sad equals model sum; addresses held during gnt=0; 64 issues; latency = 67 + stall cycles.
- cur_base=0xFFFE, stride=4, blk_size=0 -> cur_addr sequence FFFE, FFFF, 0000, 0001, then row 1 at 0002, 0003, 0004, 0005.
- start pulsed while busy -> ignored (no new latch; sad of the first block unchanged). blk_size=3 in IDLE -> cfg_err pulse, busy stays 0.
- rst=1 for one cycle during RUN at pixel 7 -> next cycle IDLE, all outputs 0, no sad_vld. A new start then completes normally with the correct sad.
